// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the byte-serial load/store unit: funct3 codes, FSM states, size decode.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Index of the final byte of an access (nbytes - 1).
  function automatic logic [1:0] last_idx(logic [1:0] sz);
    unique case (sz)
      SZ_B:    return 2'd0;
      SZ_H:    return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  // funct3 3/6/7 are never legal; stores have no unsigned forms.
  function automatic logic f3_illegal(logic [2:0] f3, logic store);
    return (f3[1:0] == 2'b11) || (f3 == 3'b110) || (store && f3[2]);
  endfunction

  function automatic logic [7:0] byte_sel(logic [31:0] w, logic [1:0] i);
    unique case (i)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

endpackage

// File: rtl/load_extender.sv
// Combinational load-result formatter: sign/zero extension of an assembled little-endian word.
module load_extender
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [31:0] asm_word,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    unique case (func3)
      F3_LB:   result = {{24{asm_word[7]}}, asm_word[7:0]};
      F3_LH:   result = {{16{asm_word[15]}}, asm_word[15:0]};
      F3_LW:   result = asm_word;
      F3_LBU:  result = {24'd0, asm_word[7:0]};
      F3_LHU:  result = {16'd0, asm_word[15:0]};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte-serial load/store initiator: splits 1/2/4-byte requests into req/ack byte accesses.
// Optional build macro MISALIGN_TRAP_EN: misaligned halfword/word requests trap without access.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_func3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_data,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack
);

  state_e            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       wdata_q;
  logic [2:0]        func3_q;
  logic              store_q;
  logic [1:0]        idx_q;
  logic [1:0]        last_q;
  logic [7:0]        wait_q;
  logic [31:0]       asm_q;

  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_wdata_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic [31:0]       resp_data_q;

  logic [31:0]       asm_next;
  logic [31:0]       ext_data;
  logic [1:0]        idx_nxt;
  logic              misalign;
  logic              req_bad;

`ifdef MISALIGN_TRAP_EN
  assign misalign = ((req_func3[1:0] == SZ_H) && req_addr[0]) ||
                    ((req_func3[1:0] == SZ_W) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign req_bad = f3_illegal(req_func3, req_store) || misalign;
  assign idx_nxt = idx_q + 2'd1;

  // Assembly word with the byte arriving this cycle already merged in.
  always_comb begin
    asm_next = asm_q;
    unique case (idx_q)
      2'd0: asm_next[7:0]   = mem_rdata;
      2'd1: asm_next[15:8]  = mem_rdata;
      2'd2: asm_next[23:16] = mem_rdata;
      2'd3: asm_next[31:24] = mem_rdata;
    endcase
  end

  load_extender u_load_extender (
    .func3    (func3_q),
    .asm_word (asm_next),
    .result   (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      wdata_q      <= '0;
      func3_q      <= '0;
      store_q      <= 1'b0;
      idx_q        <= '0;
      last_q       <= '0;
      wait_q       <= '0;
      asm_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            base_q  <= req_addr;
            wdata_q <= req_wdata;
            func3_q <= req_func3;
            store_q <= req_store;
            last_q  <= last_idx(req_func3[1:0]);
            idx_q   <= '0;
            wait_q  <= '0;
            asm_q   <= '0;
            if (req_bad) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_data_q  <= '0;
            end else begin
              state_q     <= S_ISSUE;
              mem_req_q   <= 1'b1;
              mem_we_q    <= req_store;
              mem_addr_q  <= req_addr;
              mem_wdata_q <= req_wdata[7:0];
            end
          end
        end
        S_ISSUE: begin
          if (mem_ack) begin
            if (!store_q) asm_q <= asm_next;
            if (idx_q == last_q) begin
              state_q      <= S_RESP;
              mem_req_q    <= 1'b0;
              mem_we_q     <= 1'b0;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b0;
              resp_data_q  <= store_q ? 32'd0 : ext_data;
            end else begin
              idx_q       <= idx_nxt;
              wait_q      <= '0;
              mem_addr_q  <= base_q + ADDR_W'(idx_nxt);
              mem_wdata_q <= byte_sel(wdata_q, idx_nxt);
            end
          end else if (wait_q == 8'(MAX_WAIT - 1)) begin
            // Timeout: already-written bytes stay in memory.
            state_q      <= S_RESP;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_data_q  <= '0;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        S_RESP: begin
          state_q      <= S_IDLE;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_data_q  <= '0;
          mem_addr_q   <= '0;
          mem_wdata_q  <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_data  = resp_data_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the byte-addressable data memory interface.
- Sits between the MEM pipeline stage and a byte-wide memory port.
- Accepts one load/store request per transaction and splits it into 1, 2 or 4 serial byte accesses using a req/ack handshake.
- Assembles load bytes little-endian, sign- or zero-extends per funct3, and returns one response pulse; the pipeline stalls on busy.

Parameters:
- ADDR_W, 32, width of request and memory addresses.
- MAX_WAIT, 15, cycles a byte access may wait for mem_ack before timeout (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_store  in  1  1 = store, 0 = load.
- req_func3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  valid with resp_valid: illegal funct3, timeout, or misalign trap.
- resp_data  out  32  extended load data; 0 for stores and errors.
- busy  out  1  state != IDLE; drives pipeline stall.
- mem_req  out  1  byte access request.
- mem_we  out  1  byte write enable.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  8  write byte.
- mem_rdata  in  8  read byte, valid when mem_ack=1.
- mem_ack  in  1  access complete this cycle.

Behaviour:
- Reset (async, active-low): state IDLE, all outputs 0 except req_ready=1. Internal data and index registers cleared.
- States: IDLE, ISSUE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr, wdata, func3 and store; clear idx, wait_cnt and the assembly register.
  - nbytes = 1 for func3[1:0]=00, 2 for 01, 4 for 10.
  - For func3 in {3,6,7}, or store with func3[2]=1: go to RESP with resp_err=1 and no memory access.
  - Otherwise go to ISSUE.
- ISSUE:
  - Drive mem_req=1, mem_we=store, mem_addr = base+idx (modulo 2^ADDR_W, wraps at the top of the space), mem_wdata = wdata byte idx.
  - On mem_ack for a load, capture mem_rdata into assembly byte idx.
  - On mem_ack: if idx==nbytes-1, go to RESP; else increment idx, clear wait_cnt and stay in ISSUE. mem_req stays high and the address advances the next cycle.
  - Without ack, wait_cnt increments. When wait_cnt reaches MAX_WAIT, go to RESP with resp_err=1; bytes already written are not rolled back.
- RESP:
  - resp_valid=1 for exactly one cycle, then return to IDLE. There is no response backpressure.
  - Load resp_data:
    - LB: sign-extend byte0.
    - LH: sign-extend {byte1,byte0}.
    - LW: {byte3..byte0}.
    - LBU/LHU: zero-extend.
- req_ready=0 in ISSUE and RESP; requests presented then are ignored.
- Latency with zero-wait ack: request accepted at edge T, byte k access in cycle T+1+k, resp_valid in cycle T+1+nbytes. So LW is 5 cycles accept-to-response and LB is 2.
- Reset mid-transaction: mem_req drops immediately, no response is issued, and partial stores remain in memory.
- mem_ack outside ISSUE is ignored.

Optional Feature:
- MISALIGN_TRAP_EN defined: a halfword with addr[0]≠0, or a word with addr[1:0]≠0, goes IDLE→RESP with resp_err=1 and no memory access.
- Undefined: misaligned accesses complete normally, byte-serially.

Decomposition:
- Shared package/defines (extends defines.v):
  - funct3 encodings F3_LB/LH/LW/LBU/LHU.
  - State encodings S_IDLE/S_ISSUE/S_RESP.
  - Size-decode constants.
- Sub-module load_extender: combinational func3 + 32-bit assembly → 32-bit result. Reusable by any load path.

Test Plan:
- SW addr 0x10, wdata 0xDEADBEEF, zero-wait ack → bytes EF,BE,AD,DE written to 0x10..0x13; resp_valid 5 cycles after accept, resp_err=0.
- LB addr 0x10 after the above → resp_data 0xFFFFFFEF. LBU → 0x000000EF. LH → 0xFFFFBEEF. LHU → 0x0000BEEF.
- LW with 2-cycle ack delay per byte → resp_valid 13 cycles after accept (1 + 4×3); data 0xDEADBEEF.
- mem_ack never asserted, MAX_WAIT=15 → resp_err=1 and resp_data=0, 16 cycles after accept.
- func3=3 → resp_valid and resp_err the cycle after accept; mem_req never asserts.
- LW addr 0x11 → with MISALIGN_TRAP_EN: resp_err=1, no mem_req; without it: reads 0x11..0x14. Assert rst_n low mid-ISSUE → mem_req=0 immediately and no resp_valid.
